axil_reg_arbiter: RTL and testbench

//  Shares one AXI4-Lite slave register block (4 x 32-bit regs, e.g. the counter IP) between NUM_REQ requesters.

---
 rtl/axil_arb_pkg.sv | 22 ++
 rtl/axil_reg_arbiter_rr_arb.sv | 29 ++
 rtl/axil_reg_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_axil_reg_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite register arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WB   = 3'd2,
    RA   = 3'd3,
    RD   = 3'd4
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Both error encodings share resp[1]; spelled out so the intent is obvious.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_reg_arbiter_rr_arb.sv
// Round-robin grant logic: picks the first requester after the pointer.
// Purely combinational; the owner of the pointer register is the caller.
module rr_arb #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest requester after ptr wins last.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axil_reg_arbiter.sv
// Shares one AXI4-Lite register slave between NUM_REQ simple req/rsp ports.
// One transaction outstanding; round-robin arbitration in IDLE.
// Optional macro AXIL_ARB_ADDR_CHECK_EN: reject misaligned / out-of-range
// addresses locally with an error response and no AXI traffic.
module axil_reg_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        cur_id;
  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        grant_idx;
  logic                    can_accept;
  logic                    accept;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    bad_addr;
  logic                    aw_done;
  logic                    w_done;

  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic                    awvalid_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wvalid_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic                    arvalid_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // The response cycle still belongs to the finished transaction, so hold off
  // new accepts until rsp_valid has dropped.
  assign can_accept = (state == IDLE) && !(|rsp_valid_q);
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |req_ready;

  assign sel_we    = req_we[grant_idx];
  assign sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef AXIL_ARB_ADDR_CHECK_EN
  assign bad_addr = (sel_addr[1:0] != 2'b00) || (int'(sel_addr) >= NUM_REGS * 4);
`else
  assign bad_addr = 1'b0;
`endif

  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state == WB);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state == RD);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Transaction sequencer: accept, drive the AXI channels, return the response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      cur_id      <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= grant_idx;
            cur_id <= grant_idx;
            if (bad_addr) begin
              rsp_valid_q[grant_idx] <= 1'b1;
              rsp_err_q              <= 1'b1;
              rsp_rdata_q            <= '0;
            end else if (sel_we) begin
              awaddr_q  <= sel_addr;
              wdata_q   <= sel_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR;
            end else begin
              araddr_q  <= sel_addr;
              arvalid_q <= 1'b1;
              state     <= RA;
            end
          end
        end
        WR: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done)          state     <= WB;
        end
        WB: begin
          if (m_axi_bvalid) begin
            rsp_valid_q[cur_id] <= 1'b1;
            rsp_err_q           <= resp_is_err(m_axi_bresp);
            rsp_rdata_q         <= '0;
            state               <= IDLE;
          end
        end
        RA: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= RD;
          end
        end
        RD: begin
          if (m_axi_rvalid) begin
            rsp_valid_q[cur_id] <= 1'b1;
            rsp_err_q           <= resp_is_err(m_axi_rresp);
            rsp_rdata_q         <= m_axi_rdata;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Self-checking bench for axil_reg_arbiter with a small AXI4-Lite register slave model.
// Follows the AXIL_ARB_ADDR_CHECK_EN macro for the local-reject expectations.
module tb_axil_reg_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 8;
  localparam int DW      = 32;

  logic                     ACLK = 1'b0;
  logic                     ARESETN = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_we = '0;
  logic [NUM_REQ*AW-1:0]    req_addr = '0;
  logic [NUM_REQ*DW-1:0]    req_wdata = '0;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [DW-1:0]            rsp_rdata;
  logic                     rsp_err;
  logic [AW-1:0]            m_axi_awaddr;
  logic [2:0]               m_axi_awprot;
  logic                     m_axi_awvalid;
  logic                     m_axi_awready = 1'b1;
  logic [DW-1:0]            m_axi_wdata;
  logic [DW/8-1:0]          m_axi_wstrb;
  logic                     m_axi_wvalid;
  logic                     m_axi_wready = 1'b1;
  logic [1:0]               m_axi_bresp = 2'b00;
  logic                     m_axi_bvalid = 1'b0;
  logic                     m_axi_bready;
  logic [AW-1:0]            m_axi_araddr;
  logic [2:0]               m_axi_arprot;
  logic                     m_axi_arvalid;
  logic                     m_axi_arready = 1'b1;
  logic [DW-1:0]            m_axi_rdata = '0;
  logic [1:0]               m_axi_rresp = 2'b00;
  logic                     m_axi_rvalid = 1'b0;
  logic                     m_axi_rready;

  always #5 ACLK = ~ACLK;

  axil_reg_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int compared = 0;
  int mismatched = 0;

  // Slave model state
  logic [31:0]   regs [4];
  int            aw_stall = 0;
  logic [1:0]    next_bresp = 2'b00;
  int            aw_hs_cnt = 0;
  int            b_hs_cnt = 0;
  int            ar_hs_cnt = 0;
  logic          got_aw = 1'b0;
  logic          got_w = 1'b0;
  logic [AW-1:0] lat_awaddr = '0;
  logic [31:0]   lat_wdata = '0;
  logic          b_pend = 1'b0;
  logic [1:0]    b_resp_q = 2'b00;
  logic          r_pend = 1'b0;
  logic [31:0]   r_data_q = '0;
  logic [1:0]    r_resp_q = 2'b00;

  // Monitor state
  int   rsp_cnt [NUM_REQ];
  int   reset_bad = 0;
  int   arvalid_cycles = 0;
  logic track_aw = 1'b0;
  int   aw_cycles = 0;
  int   w_first_cycles = 0;
  int   awaddr_bad = 0;

  // Register slave: sample handshakes at the edge, drive its outputs 1 ns later.
  always begin
    @(posedge ACLK);
    if (!ARESETN) begin
      got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        got_aw = 1'b1; lat_awaddr = m_axi_awaddr; aw_hs_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        got_w = 1'b1; lat_wdata = m_axi_wdata;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend = 1'b0; b_hs_cnt++;
      end
      if (got_aw && got_w) begin
        if (lat_awaddr < 8'h10) begin
          regs[lat_awaddr[3:2]] = lat_wdata;
          b_resp_q = next_bresp;
        end else begin
          b_resp_q = 2'b11;
        end
        b_pend = 1'b1; got_aw = 1'b0; got_w = 1'b0;
      end
      if (m_axi_rvalid && m_axi_rready) r_pend = 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_hs_cnt++;
        r_pend = 1'b1;
        if (m_axi_araddr < 8'h10) begin
          r_data_q = regs[m_axi_araddr[3:2]]; r_resp_q = 2'b00;
        end else begin
          r_data_q = '0; r_resp_q = 2'b11;
        end
      end
    end
    #1;
    m_axi_bvalid  = b_pend;
    m_axi_bresp   = b_resp_q;
    m_axi_rvalid  = r_pend;
    m_axi_rdata   = r_data_q;
    m_axi_rresp   = r_resp_q;
    m_axi_awready = (aw_stall == 0);
    if (m_axi_awvalid && aw_stall > 0) aw_stall--;
  end

  // Observe outputs mid-cycle: response pulses, reset quietness, AW/W ordering.
  always @(negedge ACLK) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (rsp_valid[i]) rsp_cnt[i]++;
    if (m_axi_arvalid) arvalid_cycles++;
    if (!ARESETN) begin
      if (req_ready != 0 || rsp_valid != 0 || m_axi_awvalid || m_axi_wvalid ||
          m_axi_bready || m_axi_arvalid || m_axi_rready || rsp_rdata != 0 || rsp_err)
        reset_bad++;
    end
    if (track_aw && m_axi_awvalid) begin
      aw_cycles++;
      if (!m_axi_wvalid) w_first_cycles++;
      if (m_axi_awaddr != 8'h04) awaddr_bad++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one request and wait (bounded) for its accept and response.
  task automatic applyStimulus(input int id, input logic we, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    int n;
    req_we[id]                = we;
    req_addr[id*AW +: AW]     = addr;
    req_wdata[id*DW +: DW]    = wdata;
    req_valid[id]             = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!req_ready[id] && n < 100);
    rdata = '0; err = 1'b0; lat = -1;
    if (!req_ready[id]) begin
      checkOutput("accept_timeout", 32'd1, 32'd0);
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge ACLK);
    #1;
    req_valid[id] = 1'b0;
    lat = 0;
    do begin
      @(negedge ACLK);
      lat++;
    end while (!rsp_valid[id] && lat < 100);
    if (!rsp_valid[id]) begin
      checkOutput("rsp_timeout", 32'd1, 32'd0);
      lat = -1;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge ACLK);
    #1;
  endtask

  typedef struct {
    int          id;
    logic        we;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [1:0]  bresp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [13];

  task automatic runVectors(input int first, input int last);
    logic [31:0] rd;
    logic        er;
    int          lt;
    for (int i = first; i <= last; i++) begin
      next_bresp = vecs[i].bresp;
      applyStimulus(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lt);
      checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_latency", i), lt, vecs[i].exp_lat);
    end
    next_bresp = 2'b00;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;
    int          c0, c1, snap_b, snap_aw, snap_ar, snap_arv;
    int          gcount, n;
    logic [NUM_REQ-1:0] grant_seq [6];

    for (int i = 0; i < NUM_REQ; i++) rsp_cnt[i] = 0;
    for (int i = 0; i < 4; i++) regs[i] = '0;

    vecs[0]  = '{0, 1'b1, 8'h00, 32'h1,        2'b00, 32'h0,        1'b0, 3};
    vecs[1]  = '{0, 1'b1, 8'h04, 32'h2,        2'b00, 32'h0,        1'b0, 3};
    vecs[2]  = '{0, 1'b1, 8'h08, 32'h3,        2'b00, 32'h0,        1'b0, 3};
    vecs[3]  = '{0, 1'b1, 8'h0C, 32'h4,        2'b00, 32'h0,        1'b0, 3};
    vecs[4]  = '{0, 1'b0, 8'h00, 32'h0,        2'b00, 32'h1,        1'b0, 3};
    vecs[5]  = '{0, 1'b0, 8'h04, 32'h0,        2'b00, 32'h2,        1'b0, 3};
    vecs[6]  = '{0, 1'b0, 8'h08, 32'h0,        2'b00, 32'h3,        1'b0, 3};
    vecs[7]  = '{0, 1'b0, 8'h0C, 32'h0,        2'b00, 32'h4,        1'b0, 3};
    vecs[8]  = '{1, 1'b1, 8'h08, 32'hDEADBEEF, 2'b00, 32'h0,        1'b0, 3};
    vecs[9]  = '{1, 1'b0, 8'h08, 32'h0,        2'b00, 32'hDEADBEEF, 1'b0, 3};
    vecs[10] = '{0, 1'b1, 8'h00, 32'hA5A5,     2'b10, 32'h0,        1'b1, 3};
    vecs[11] = '{1, 1'b1, 8'h04, 32'h77,       2'b00, 32'h0,        1'b0, 3};
    vecs[12] = '{1, 1'b0, 8'h04, 32'h0,        2'b00, 32'h77,       1'b0, 3};

    // Reset held for 20 cycles with outputs watched every cycle
    ARESETN = 1'b0;
    repeat (20) @(negedge ACLK);
    checkOutput("reset_outputs_quiet", reset_bad, 0);
    checkOutput("reset_no_aw_traffic", aw_hs_cnt, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checkOutput("idle_req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("idle_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge ACLK);
    #1;

    // Write four registers then read them back
    c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
    runVectors(0, 3);
    checkOutput("write_phase_pulses", rsp_cnt[0] - c0, 4);
    c0 = rsp_cnt[0];
    runVectors(4, 7);
    checkOutput("read_phase_pulses", rsp_cnt[0] - c0, 4);
    checkOutput("other_port_quiet", rsp_cnt[1] - c1, 0);

    // Requester 1 traffic, SLVERR on one write only
    runVectors(8, 12);

    // Both requesters hold req_valid; grants must alternate starting at 0
    req_we = '0;
    req_addr[0 +: AW]  = 8'h00;
    req_addr[AW +: AW] = 8'h04;
    req_valid = 2'b11;
    gcount = 0; n = 0;
    while (gcount < 6 && n < 300) begin
      @(negedge ACLK);
      n++;
      if (req_ready != 0) begin
        grant_seq[gcount] = req_ready;
        gcount++;
      end
    end
    @(posedge ACLK);
    #1;
    req_valid = '0;
    checkOutput("alternate_grant_count", gcount, 6);
    for (int k = 0; k < gcount; k++)
      checkOutput($sformatf("alternate_grant%0d", k), {30'd0, grant_seq[k]},
                  (k % 2 == 0) ? 32'd1 : 32'd2);
    repeat (20) @(posedge ACLK);
    #1;

    // awready stalled 5 cycles with immediate wready
    snap_b = b_hs_cnt; snap_aw = aw_hs_cnt;
    aw_stall = 5;
    track_aw = 1'b1;
    applyStimulus(0, 1'b1, 8'h04, 32'h55, rd, er, lt);
    track_aw = 1'b0;
    checkOutput("stall_latency", lt, 8);
    checkOutput("stall_err", {31'd0, er}, 32'd0);
    checkOutput("stall_aw_cycles", aw_cycles, 6);
    checkOutput("stall_w_first", w_first_cycles, 5);
    checkOutput("stall_awaddr_stable", awaddr_bad, 0);
    checkOutput("stall_one_b", b_hs_cnt - snap_b, 1);
    checkOutput("stall_one_aw", aw_hs_cnt - snap_aw, 1);
    applyStimulus(0, 1'b0, 8'h04, 32'h0, rd, er, lt);
    checkOutput("stall_readback", rd, 32'h55);

    // Out-of-range and misaligned reads
    snap_ar = ar_hs_cnt; snap_arv = arvalid_cycles;
    applyStimulus(0, 1'b0, 8'h10, 32'h0, rd, er, lt);
`ifdef AXIL_ARB_ADDR_CHECK_EN
    checkOutput("oor_latency", lt, 1);
    checkOutput("oor_err", {31'd0, er}, 32'd1);
    checkOutput("oor_rdata", rd, 32'h0);
    checkOutput("oor_no_ar", ar_hs_cnt - snap_ar, 0);
`else
    checkOutput("oor_latency", lt, 3);
    checkOutput("oor_err", {31'd0, er}, 32'd1);
    checkOutput("oor_ar_sent", ar_hs_cnt - snap_ar, 1);
`endif
    snap_ar = ar_hs_cnt;
    applyStimulus(0, 1'b0, 8'h02, 32'h0, rd, er, lt);
`ifdef AXIL_ARB_ADDR_CHECK_EN
    checkOutput("misalign_latency", lt, 1);
    checkOutput("misalign_err", {31'd0, er}, 32'd1);
    checkOutput("misalign_no_ar", ar_hs_cnt - snap_ar, 0);
    checkOutput("reject_no_arvalid", arvalid_cycles - snap_arv, 0);
`else
    checkOutput("misalign_latency", lt, 3);
    checkOutput("misalign_err", {31'd0, er}, 32'd0);
    checkOutput("misalign_rdata", rd, 32'hA5A5);
    checkOutput("misalign_ar_sent", ar_hs_cnt - snap_ar, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
